// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// The channel is chosen either by an external select (fixed mode) or by a
// round-robin arbiter among the valid channels. The grant is combinational,
// so a mode or select change acts in the same cycle. The output register
// accepts a new word whenever it is empty or being drained.
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_chan_reg;
  logic [SELW-1:0]  ptr_reg;
  logic [SELW-1:0]  ptr_next;

  logic             load_en;
  logic             fix_hit;
  logic             rr_hit;
  logic [SELW-1:0]  rr_idx;
  logic             any_grant;
  logic [SELW-1:0]  grant_idx;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] chan_data [N];

  // The register can take a word when empty or when its word leaves this cycle
  assign load_en = !out_valid_reg || out_ready;

  // Fixed mode: a select outside the channel range never grants
  assign fix_hit = (32'(sel) < N) && in_valid[sel];

  // Round-robin: first valid channel at or after ptr, wrapping modulo N.
  // Scanning offsets from high to low lets the smallest offset win last.
  always_comb begin
    logic [SELW:0] sum;
    rr_hit = 1'b0;
    rr_idx = '0;
    sum    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_reg} + (SELW + 1)'(k);
      if (sum >= (SELW + 1)'(N)) begin
        sum = sum - (SELW + 1)'(N);
      end
      if (in_valid[sum[SELW-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = sum[SELW-1:0];
      end
    end
  end

  assign any_grant = mode ? rr_hit : fix_hit;
  assign grant_idx = mode ? rr_idx : sel;

  // Pointer moves just past the granted channel, wrapping N-1 back to 0
  assign ptr_next = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);

  // Per-channel data unpacking, one-hot grant and ready (held low in reset)
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign grant[gi]     = any_grant && (grant_idx == SELW'(gi));
      assign in_ready[gi]  = rst_n && load_en && grant[gi];
    end
  endgenerate

  // Output register and arbitration pointer; reset drops any held word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      ptr_reg       <= '0;
    end else if (load_en) begin
      if (any_grant) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= chan_data[grant_idx];
        out_chan_reg  <= grant_idx;
        if (mode) begin
          ptr_reg <= ptr_next;
        end
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed and randomized checks of stream_mux_rr against a behavioural
// model of the output register and arbitration rules.
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [1:0]     sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_ready;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: contents of the output stage and the rotation pointer
  bit mv;
  int md;
  int mc;
  int mp;

  stream_mux_rr #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int word_of(input int c);
    logic [N*W-1:0] d;
    d = in_data >> (c * W);
    return int'(d[W-1:0]);
  endfunction

  // Which channel the rules grant now, or -1
  function automatic int ref_grant();
    if (!mode) begin
      return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mp + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    mv = 1'b0; md = 0; mc = 0; mp = 0;
  endfunction

  // One clock: check ready, advance model, check registered outputs
  task automatic cycle(input string tag);
    int g;
    bit load;
    logic [N-1:0] er;
    bit nv;
    int nd, nc, np;
    #1;
    g = ref_grant();
    load = !mv || out_ready;
    er = (g >= 0 && load) ? (N'(1) << g) : '0;
    chk({tag, ":in_ready"}, 32'(in_ready), 32'(er));
    nv = mv; nd = md; nc = mc; np = mp;
    if (load) begin
      if (g >= 0) begin
        nv = 1'b1; nd = word_of(g); nc = g;
        if (mode) np = (g + 1) % N;
      end else begin
        nv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    mv = nv; md = nd; mc = nc; mp = np;
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(mv));
    chk({tag, ":out_data"}, 32'(out_data), 32'(md));
    chk({tag, ":out_chan"}, 32'(out_chan), 32'(mc));
  endtask

  initial begin
    // Reset: outputs cleared and in_ready low even with valid inputs
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'hF;
    in_data = 16'h4321; out_ready = 1'b1;
    model_reset();
    #2;
    chk("rst:in_ready", 32'(in_ready), 32'h0);
    chk("rst:out_valid", 32'(out_valid), 32'h0);
    chk("rst:out_data", 32'(out_data), 32'h0);
    chk("rst:out_chan", 32'(out_chan), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_edge:in_ready", 32'(in_ready), 32'h0);
    chk("rst_edge:out_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;

    // Scenario 1: fixed select of channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 16'h0A00; out_ready = 1'b1;
    #1;
    chk("s1:in_ready_0100", 32'(in_ready), 32'h4);
    cycle("s1");
    chk("s1:data_A", 32'(out_data), 32'hA);
    chk("s1:chan_2", 32'(out_chan), 32'h2);

    // Scenario 2: backpressure holds the word, then B follows exactly once
    out_ready = 1'b0; in_data = 16'h0B00;
    for (int i = 0; i < 3; i++) begin
      cycle("s2_hold");
      chk("s2_hold:data_A", 32'(out_data), 32'hA);
    end
    out_ready = 1'b1;
    cycle("s2_release");
    chk("s2_release:data_B", 32'(out_data), 32'hB);
    in_valid = 4'b0000;
    cycle("s2_drain");
    chk("s2_drain:no_dup", 32'(out_valid), 32'h0);

    // Scenario 3: round-robin over four always-valid channels
    mode = 1'b1; in_valid = 4'hF; in_data = 16'h4321;
    for (int k = 0; k < 8; k++) begin
      cycle("s3");
      chk("s3:chan_seq", 32'(out_chan), 32'(k % 4));
      chk("s3:data_seq", 32'(out_data), 32'(k % 4 + 1));
    end

    // Scenario 4: pointer at 1 skips to ch3, then wraps to ch0, ptr -> 1
    in_valid = 4'b0001;
    cycle("s4_setptr");
    in_valid = 4'b1001;
    cycle("s4_a");
    chk("s4:first_ch3", 32'(out_chan), 32'h3);
    cycle("s4_b");
    chk("s4:then_ch0", 32'(out_chan), 32'h0);
    in_valid = 4'hF;
    cycle("s4_c");
    chk("s4:ptr_wrap_ch1", 32'(out_chan), 32'h1);

    // Scenario 5: fixed select of an idle channel -> no grant, word drains
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1101;
    cycle("s5");
    chk("s5:drained", 32'(out_valid), 32'h0);
    cycle("s5_idle");

    // Scenario 6: asynchronous reset while a word is held
    sel = 2'd0; in_valid = 4'b0001; in_data = 16'h0007;
    cycle("s6_load");
    out_ready = 1'b0; in_valid = 4'b0000;
    cycle("s6_hold");
    chk("s6:held_valid", 32'(out_valid), 32'h1);
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("s6:async_valid", 32'(out_valid), 32'h0);
    chk("s6:async_data", 32'(out_data), 32'h0);
    chk("s6:async_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("s6:in_reset_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1; in_data = 16'h4321;
    cycle("s6_rr");
    chk("s6:restart_ch0", 32'(out_chan), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer. Successor to the plain 4-bit 2:1 combinational mux.
- Adds a registered output stage and valid/ready handshakes on every channel.
- Selection mode is chosen at runtime:
  - fixed: an external select picks the channel.
  - round-robin: fair arbitration among valid channels.
- Sits between multiple producers and one consumer in the datapath.

Parameters:
- WIDTH, 4, data width per channel (>=1).
- N, 4, number of input channels (>=2).
- SELW, $clog2(N), derived localparam; width of select and channel-id fields. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- in_valid  input  N  per-channel valid.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready; combinational.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered data.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset:
  - Asynchronous; asserted while rst_n=0.
  - out_valid=0, out_data=0, out_chan=0, rr pointer=0.
  - in_ready=0 throughout reset.
- Load enable: load_en = !out_valid | out_ready. The output register can accept a new word when empty or when being drained in the same cycle.
- Grant, fixed mode (mode=0):
  - If sel<N and in_valid[sel]=1, grant channel sel.
  - Otherwise no grant, including sel>=N when N is not a power of 2.
- Grant, round-robin mode (mode=1):
  - Grant the first channel with in_valid=1, searching from ptr upward modulo N.
  - No grant if in_valid is all zero.
- in_ready[i] = load_en & grant[i]. At most one bit of in_ready is set.
  - in_ready must not depend on in_valid of a non-granted channel in a way that creates a loop.
  - in_data may be ignored when no grant is made.
- Transfer on channel i: grant[i] & load_en. On the next clock edge:
  - out_data <= in_data[i]
  - out_chan <= i
  - out_valid <= 1
- Drain without reload: out_valid & out_ready and no grant -> out_valid <= 0. out_data and out_chan keep their old values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_chan and out_valid are held stable and in_ready is all zero.
- Latency and throughput:
  - 1 cycle from input transfer to out_valid.
  - Sustained throughput of 1 word/cycle when out_ready=1.
- Round-robin pointer:
  - Updates only on a transfer in mode=1: ptr <= (granted+1) mod N, wrapping N-1 -> 0.
  - Unchanged in fixed mode, so switching mode resumes the rotation.
- Mode or sel change: takes effect in the same cycle (grant is combinational). A word already in the output register is unaffected.
- Reset mid-operation: any held word is dropped, out_valid falls immediately, and no transfer is reported.

Test Plan:
All scenarios use WIDTH=4, N=4.
1. Fixed mode, mode=0, sel=2, in_valid=4'b0100, ch2 data=4'hA, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'hA, out_chan=2.
2. Backpressure: continue scenario 1 with out_ready=0 for 3 cycles while ch2 changes to 4'hB -> out_data stays 4'hA and in_ready=0. Raise out_ready -> 4'hB appears on the following cycle, with no loss and no duplication.
3. Round-robin fairness: mode=1, in_valid=4'b1111, data ch0..3 = 1,2,3,4, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 and out_data sequence 1,2,3,4,1,2,3,4.
4. Round-robin skip: mode=1, ptr=1, in_valid=4'b1001 -> ch3 granted first, then ch0; ptr wraps 0 -> 1.
5. Idle/invalid select: mode=0, sel=1, in_valid=4'b1101 -> no grant, in_ready=0, out_valid falls after the current word drains.
6. Reset mid-stream: out_valid=1, out_ready=0, pulse rst_n low mid-cycle -> out_valid=0 and out_data=0 asynchronously. After release, round-robin restarts at ch0.
